// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS-subset control unit: Moore FSM sequencing fetch/decode/execute
// phases, with memory handshake stalls and a retired-instruction counter.
module multicycle_control_fsm #(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic [3:0]  state,
  output logic        illegal_op,
  output logic [31:0] instr_retired
);

  localparam int unsigned ST_W  = 4;
  localparam int unsigned CNT_W = 32;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_ORIEX  = 4'd9;
  localparam logic [3:0] S_ORIWB  = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  logic [ST_W-1:0] state_d;
  logic            ready;
  logic            retire;

  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  // State register and retired-instruction counter (wraps naturally)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_FETCH;
      instr_retired <= '0;
    end else begin
      state         <= state_d;
      instr_retired <= instr_retired + CNT_W'(retire);
    end
  end

  // Next-state and control decode
  always_comb begin
    state_d       = S_FETCH;
    retire        = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    pc_source     = 2'b00;
    illegal_op    = 1'b0;

    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = ready;
        pc_write  = ready;
        state_d   = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ORI:       state_d = S_ORIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
        state_d  = ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
      end
      S_MEMWR: begin
        iord      = 1'b1;
        mem_write = 1'b1;
        state_d   = ready ? S_FETCH : S_MEMWR;
        retire    = ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'b10;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
      end
      S_ORIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
        state_d   = S_ORIWB;
      end
      S_ORIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase

    // Strobes are held quiet for the whole reset window, not just after the edge
    if (!rst_n) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      illegal_op    = 1'b0;
    end
  end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have parameter: MEM_HANDSHAKE, 1, when 1 memory states wait on mem_ready; when 0 mem_ready is treated as constant 1.
REQ-002 SHALL have ports, one per line:
  clk  in  1  rising-edge clock
  rst_n  in  1  asynchronous active-low reset
  opcode  in  6  instruction[31:26] from the instruction register
  mem_ready  in  1  memory access completes this cycle
  pc_write, pc_write_cond  out  1 each  PC enable / branch-conditional PC enable
  iord  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
  mem_read, mem_write, ir_write  out  1 each  memory and IR strobes
  reg_dst, mem_to_reg, reg_write  out  1 each  register-file controls
  alu_src_a  out  1  0 = PC, 1 = A
  alu_src_b  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
  alu_op  out  2  to the ALU control unit: 00 add, 01 sub, 10 funct, 11 ori
  pc_source  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
  state  out  4  current state code
  illegal_op  out  1  unrecognised opcode in DECODE
  instr_retired  out  32  count of completed instructions

Function
REQ-003 SHALL be a Moore FSM; outputs decode from state only, except FETCH/MEMRD/MEMWR strobes and illegal_op as stated.
REQ-004 State codes SHALL be: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ORIEX 9, ORIWB 10, JUMP 11.
REQ-005 Any output not listed for a state SHALL be 0.
REQ-006 FETCH: mem_read=1, alu_src_b=01, alu_op=00; ir_write=pc_write=mem_ready; hold FETCH while mem_ready=0, else go to DECODE.
REQ-007 DECODE: alu_src_b=11, alu_op=00; next by opcode: 100011/101011 -> MEMADR, 000000 -> EXEC, 000100 -> BRANCH, 001101 -> ORIEX, 000010 -> JUMP.
REQ-008 DECODE with any other opcode SHALL assert illegal_op for that cycle and go to FETCH.
REQ-009 MEMADR: alu_src_a=1, alu_src_b=10, alu_op=00; -> MEMRD if opcode=100011, else MEMWR.
REQ-010 MEMRD: iord=1, mem_read=1; hold while mem_ready=0, else go to MEMWB.
REQ-011 MEMWB: mem_to_reg=1, reg_write=1, reg_dst=0; -> FETCH.
REQ-012 MEMWR: iord=1, mem_write=1; hold while mem_ready=0, else go to FETCH.
REQ-013 EXEC: alu_src_a=1, alu_src_b=00, alu_op=10 -> ALUWB. ALUWB: reg_dst=1, reg_write=1 -> FETCH.
REQ-014 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01 -> FETCH.
REQ-015 ORIEX: alu_src_a=1, alu_src_b=10, alu_op=11 -> ORIWB. ORIWB: reg_write=1, reg_dst=0 -> FETCH.
REQ-016 JUMP: pc_write=1, pc_source=10 -> FETCH.
REQ-017 Codes 12-15 SHALL drive all outputs 0 and go to FETCH on the next edge, without counting.
REQ-018 instr_retired SHALL increment by 1 on each edge leaving MEMWB, MEMWR (with mem_ready), ALUWB, BRANCH, ORIWB or JUMP; it wraps 0xFFFFFFFF -> 0; illegal opcodes do not count.
REQ-019 opcode SHALL be sampled only in DECODE and MEMADR; opcode changes elsewhere SHALL have no effect.
REQ-020 Latencies with mem_ready=1: lw 5, sw 4, R-type 4, ori 4, beq 3, j 3 cycles.

Reset
REQ-021 rst_n=0 SHALL asynchronously set state=FETCH and instr_retired=0.
REQ-022 While rst_n=0, pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write and illegal_op SHALL be 0; mux selects take FETCH values.
REQ-023 Reset asserted mid-instruction SHALL abandon it; no count; after release, FETCH starts on the first edge.

Verification
REQ-024 rst_n low, then release, mem_ready=1, opcode=100011 -> states 0,1,2,3,4,0; reg_write=1 only in state 4; instr_retired=1.
REQ-025 opcode=101011, mem_ready low for 3 cycles in MEMWR -> state holds at 5 for 4 cycles, mem_write=1 throughout, then FETCH; count +1.
REQ-026 opcode=000000 then 000100 then 001101 -> alu_op 10 in EXEC, 01 in BRANCH, 11 in ORIEX; count = 3.
REQ-027 opcode=111111 in DECODE -> illegal_op=1 for one cycle, next state 0, count unchanged.
REQ-028 mem_ready=0 in FETCH for 2 cycles -> ir_write=pc_write=0 while waiting, 1 on the ready cycle; instr_retired preset 0xFFFFFFFF after a j -> 0.
REQ-029 rst_n pulsed low in MEMRD -> state=0 immediately, strobes 0, count 0.
